// File: rtl/saratoga_pkg.sv
// Shared constants, state type and priority encoder for the machine-level
// interrupt controller.
package saratoga_pkg;

  localparam logic [11:0] CSR_MIE = 12'h304;
  localparam logic [11:0] CSR_MIP = 12'h344;

  localparam logic [31:0] MCAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] MCAUSE_MTI = 32'h8000_0007;
  localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;

  localparam int MSIP_BIT = 3;
  localparam int MTIP_BIT = 7;
  localparam int MEIP_BIT = 11;

  localparam logic [31:0] IRQ_MASK = 32'h0000_0888;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    BUSY = 2'd2
  } irq_state_t;

  // Fixed priority: external > software > timer.
  function automatic logic [31:0] irq_cause(input logic [31:0] pending);
    if (pending[MEIP_BIT])      return MCAUSE_MEI;
    else if (pending[MSIP_BIT]) return MCAUSE_MSI;
    else if (pending[MTIP_BIT]) return MCAUSE_MTI;
    else                        return 32'h0;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level; all stages clear
// asynchronously on reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_p <= '0;
    else     sync_p <= {sync_p[STAGES-2:0], din};
  end

  assign dout = sync_p[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// Machine interrupt controller: MSIP register, mie/mip CSRs and a three-state
// trap request handshake towards the core.
module irq_ctrl
  import saratoga_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtip,
  input  logic        ext_irq,
  input  logic        mstatus_mie,
  input  logic        dbus_rd_en,
  input  logic        dbus_wr_en,
  input  logic [31:0] dbus_wr_data,
  input  logic [3:0]  dbus_wr_strobe,
  output logic [31:0] dbus_rd_data,
  input  logic        csr_rd_en,
  input  logic        csr_wr_en,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wr_data,
  output logic [31:0] csr_rd_data,
  output logic        trap_req,
  output logic [31:0] trap_cause,
  input  logic        trap_ack,
  input  logic        mret
);

  irq_state_t  state;
  logic        mtip_p0;
  logic        meip_sync;
  logic        msip;
  logic [31:0] mie;
  logic [31:0] mip;
  logic [31:0] pending;
  logic        eligible;
  logic        unused_bits;

  assign unused_bits = ^{dbus_wr_data[31:1], dbus_wr_strobe[3:1]};

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ext (
    .clk  (clk),
    .rst  (rst),
    .din  (ext_irq),
    .dout (meip_sync)
  );

  // Source capture and software-visible registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtip_p0 <= 1'b0;
      msip    <= 1'b0;
      mie     <= '0;
    end else begin
      mtip_p0 <= mtip;
      if (dbus_wr_en && dbus_wr_strobe[0])
        msip <= dbus_wr_data[0];
      if (csr_wr_en && csr_addr == CSR_MIE)
        mie <= csr_wr_data & IRQ_MASK;
    end
  end

  always_comb begin
    mip           = '0;
    mip[MSIP_BIT] = msip;
    mip[MTIP_BIT] = mtip_p0;
    mip[MEIP_BIT] = meip_sync;
  end

  assign pending  = mip & mie;
  assign eligible = mstatus_mie && (pending != '0);

  always_comb begin
    csr_rd_data = '0;
    if (csr_rd_en) begin
      if (csr_addr == CSR_MIE)      csr_rd_data = mie;
      else if (csr_addr == CSR_MIP) csr_rd_data = mip;
    end
  end

  assign dbus_rd_data = dbus_rd_en ? {31'b0, msip} : 32'h0;

  // Trap handshake; the cause is frozen at the IDLE->PEND edge so the core
  // sees a stable value even if the source or enables drop while pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      trap_req   <= 1'b0;
      trap_cause <= '0;
    end else begin
      case (state)
        IDLE: if (eligible) begin
          state      <= PEND;
          trap_req   <= 1'b1;
          trap_cause <= irq_cause(pending);
        end
        PEND: if (trap_ack) begin
          state    <= BUSY;
          trap_req <= 1'b0;
        end
        BUSY: if (mret) state <= IDLE;
        default: begin
          state    <= IDLE;
          trap_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: expectations are queued when stimulus is
// applied and retired when the matching DUT output appears.
module tb_irq_ctrl;

  localparam logic [31:0] C_MSI = 32'h8000_0003;
  localparam logic [31:0] C_MTI = 32'h8000_0007;
  localparam logic [31:0] C_MEI = 32'h8000_000B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mtip = 1'b0;
  logic        ext_irq = 1'b0;
  logic        mstatus_mie = 1'b0;
  logic        dbus_rd_en = 1'b0;
  logic        dbus_wr_en = 1'b0;
  logic [31:0] dbus_wr_data = '0;
  logic [3:0]  dbus_wr_strobe = '0;
  logic [31:0] dbus_rd_data;
  logic        csr_rd_en = 1'b0;
  logic        csr_wr_en = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wr_data = '0;
  logic [31:0] csr_rd_data;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic        trap_ack = 1'b0;
  logic        mret = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] sb_val[$];
  string       sb_tag[$];

  irq_ctrl #(.SYNC_STAGES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .mtip           (mtip),
    .ext_irq        (ext_irq),
    .mstatus_mie    (mstatus_mie),
    .dbus_rd_en     (dbus_rd_en),
    .dbus_wr_en     (dbus_wr_en),
    .dbus_wr_data   (dbus_wr_data),
    .dbus_wr_strobe (dbus_wr_strobe),
    .dbus_rd_data   (dbus_rd_data),
    .csr_rd_en      (csr_rd_en),
    .csr_wr_en      (csr_wr_en),
    .csr_addr       (csr_addr),
    .csr_wr_data    (csr_wr_data),
    .csr_rd_data    (csr_rd_data),
    .trap_req       (trap_req),
    .trap_cause     (trap_cause),
    .trap_ack       (trap_ack),
    .mret           (mret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    sb_tag.push_back(tag);
    sb_val.push_back(val);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    if (sb_val.size() == 0) check("sb_underflow", 32'd1, 32'd0);
    else check(sb_tag.pop_front(), obs, sb_val.pop_front());
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_wr_en = 1'b1; csr_addr = addr; csr_wr_data = data;
    cyc(1);
    csr_wr_en = 1'b0;
  endtask

  task automatic csr_read(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    sb_push(tag, exp);
    csr_rd_en = 1'b1; csr_addr = addr;
    #1 sb_pop(csr_rd_data);
    csr_rd_en = 1'b0;
    cyc(1);
  endtask

  task automatic dbus_write(input logic [31:0] data, input logic [3:0] strb);
    dbus_wr_en = 1'b1; dbus_wr_data = data; dbus_wr_strobe = strb;
    cyc(1);
    dbus_wr_en = 1'b0; dbus_wr_strobe = 4'b0;
  endtask

  task automatic dbus_read(input string tag, input logic [31:0] exp);
    sb_push(tag, exp);
    dbus_rd_en = 1'b1;
    #1 sb_pop(dbus_rd_data);
    dbus_rd_en = 1'b0;
    cyc(1);
  endtask

  // Waits a bounded number of edges for trap_req, then retires the queued cause.
  task automatic wait_trap(input string tag, input int max_cyc);
    int n = 0;
    while (!trap_req && n < max_cyc) begin
      cyc(1);
      n++;
    end
    if (!trap_req) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      void'(sb_val.pop_front());
      void'(sb_tag.pop_front());
    end else begin
      sb_pop(trap_cause);
    end
  endtask

  task automatic retire();
    trap_ack = 1'b1; cyc(1); trap_ack = 1'b0;
    mret = 1'b1;     cyc(1); mret = 1'b0;
  endtask

  initial begin
    // Reset state
    cyc(2);
    check("rst_trap_req", {31'b0, trap_req}, 32'd0);
    check("rst_trap_cause", trap_cause, 32'd0);
    csr_read("rst_mie", 12'h304, 32'h0);
    rst = 1'b0;
    cyc(1);

    // CSR mask, read-only mip, unmapped address, read enable gating
    csr_write(12'h304, 32'hFFFF_FFFF);
    csr_read("mie_mask", 12'h304, 32'h0000_0888);
    csr_read("mip_before", 12'h344, 32'h0);
    csr_write(12'h344, 32'hFFFF_FFFF);
    csr_read("mip_after_wr", 12'h344, 32'h0);
    csr_read("unmapped", 12'h300, 32'h0);
    csr_addr = 12'h304; #1;
    check("rd_en_low", csr_rd_data, 32'h0);

    // DBus byte strobe
    dbus_write(32'h1, 4'b0010);
    dbus_read("msip_strb1", 32'h0);
    dbus_write(32'h1, 4'b0001);
    dbus_read("msip_strb0", 32'h1);
    sb_push("dbus_rd_en_low", 32'h0);
    sb_pop(dbus_rd_data);
    dbus_write(32'h0, 4'b0001);

    // Timer interrupt, ack, BUSY masking, back-to-back after mret
    mstatus_mie = 1'b1;
    csr_write(12'h304, 32'h80);
    mtip = 1'b1;
    sb_push("mti_cause", C_MTI);
    wait_trap("mti", 2);
    trap_ack = 1'b1; cyc(1); trap_ack = 1'b0;
    check("ack_drops_req", {31'b0, trap_req}, 32'd0);
    cyc(3);
    check("busy_no_req", {31'b0, trap_req}, 32'd0);
    mret = 1'b1; cyc(1); mret = 1'b0;
    check("mret_edge_req", {31'b0, trap_req}, 32'd0);
    sb_push("b2b_cause", C_MTI);
    cyc(1);
    check("b2b_req", {31'b0, trap_req}, 32'd1);
    sb_pop(trap_cause);
    mtip = 1'b0;
    retire();

    // Sticky cause while pending
    csr_write(12'h304, 32'h80);
    mtip = 1'b1;
    sb_push("sticky_first", C_MTI);
    wait_trap("sticky", 4);
    mtip = 1'b0;
    csr_write(12'h304, 32'h0);
    cyc(2);
    check("sticky_req", {31'b0, trap_req}, 32'd1);
    check("sticky_cause", trap_cause, C_MTI);
    retire();
    check("sticky_ack_idle", {31'b0, trap_req}, 32'd0);

    // Priority with all three sources
    mstatus_mie = 1'b0;
    csr_write(12'h304, 32'h888);
    mtip = 1'b1; ext_irq = 1'b1;
    dbus_write(32'h1, 4'b0001);
    cyc(3);
    csr_read("mip_all", 12'h344, 32'h888);
    mstatus_mie = 1'b1;
    sb_push("prio_mei", C_MEI);
    wait_trap("mei", 3);
    trap_ack = 1'b1; ext_irq = 1'b0; cyc(1); trap_ack = 1'b0;
    cyc(3);
    mret = 1'b1; cyc(1); mret = 1'b0;
    sb_push("prio_msi", C_MSI);
    wait_trap("msi", 3);
    dbus_write(32'h0, 4'b0001);
    mtip = 1'b0;
    retire();

    // mie write racing eligibility uses the old mie
    csr_write(12'h304, 32'h0);
    mtip = 1'b1;
    cyc(2);
    check("mie0_no_req", {31'b0, trap_req}, 32'd0);
    csr_write(12'h304, 32'h80);
    check("pre_write_mie", {31'b0, trap_req}, 32'd0);
    sb_push("post_write_mie", C_MTI);
    wait_trap("post_write", 1);
    mtip = 1'b0;
    retire();

    // Simultaneous DBus and CSR writes
    mstatus_mie = 1'b0;
    dbus_wr_en = 1'b1; dbus_wr_data = 32'h1; dbus_wr_strobe = 4'b0001;
    csr_wr_en = 1'b1; csr_addr = 12'h304; csr_wr_data = 32'h8;
    cyc(1);
    dbus_wr_en = 1'b0; dbus_wr_strobe = 4'b0; csr_wr_en = 1'b0;
    csr_read("dual_mie", 12'h304, 32'h8);
    dbus_read("dual_msip", 32'h1);
    csr_read("dual_mip", 12'h344, 32'h8);
    dbus_write(32'h0, 4'b0001);

    // Asynchronous reset while pending
    mstatus_mie = 1'b1;
    csr_write(12'h304, 32'h80);
    mtip = 1'b1;
    sb_push("pre_rst_cause", C_MTI);
    wait_trap("pre_rst", 3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_req", {31'b0, trap_req}, 32'd0);
    check("async_rst_cause", trap_cause, 32'd0);
    mtip = 1'b0;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    csr_read("post_rst_mie", 12'h304, 32'h0);
    dbus_read("post_rst_msip", 32'h0);
    check("sb_drained", sb_val.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
